mpy_seq_ctrl: RTL and testbench

Operand sequencer and result collector wrapped around the unsigned 4-bit carry-save array multiplier. It accepts operand pairs over a valid/ready handshake and drives them onto the multiplier inputs. It holds the operands stable until the multiplier's registered carry ripple has settled, then captures the 8-bit product into an output register with its own valid/ready handshake. A built-in checker compares each captured product against a behavioural reference product and raises a sticky error flag on any mismatch.

---
 rtl/mpy_seq_ctrl.sv | 80 ++++++++
 tb/tb_mpy_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpy_seq_ctrl.sv
// Operand sequencer and product collector for an unsigned 4x4 carry-save array multiplier.
// Holds operands until the multiplier has settled, captures the product and self-checks it.
module mpy_seq_ctrl #(
    parameter int SETTLE = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] mpy_a,
    output logic [3:0] mpy_b,
    input  logic [7:0] mpy_p,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_p,
    output logic       err,
    output logic [7:0] ops_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    logic [3:0] cnt;
    logic       can_cap;
    logic [7:0] ref_p;

    assign in_ready = (state == IDLE);
    assign can_cap  = !out_valid || out_ready;
    assign ref_p    = {4'b0000, mpy_a} * {4'b0000, mpy_b};

    // A capture on the same edge as an output handshake overrides the clear of out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mpy_a     <= 4'd0;
            mpy_b     <= 4'd0;
            out_p     <= 8'h00;
            out_valid <= 1'b0;
            err       <= 1'b0;
            ops_cnt   <= 8'h00;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mpy_a <= in_a;
                        mpy_b <= in_b;
                        cnt   <= SETTLE_CNT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (can_cap) begin
                        out_p     <= mpy_p;
                        out_valid <= 1'b1;
                        ops_cnt   <= ops_cnt + 8'd1;
                        if (mpy_p != ref_p) begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpy_seq_ctrl.sv
// Self-checking bench for mpy_seq_ctrl with a delayed behavioural multiplier in the loop.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_mpy_seq_ctrl;

    localparam int SETTLE = 6;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] mpy_a;
    logic [3:0] mpy_b;
    logic [7:0] mpy_p;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_p;
    logic       err;
    logic [7:0] ops_cnt;

    logic [7:0] p1, p2, p3;
    logic [7:0] injectMask;

    int checks   = 0;
    int failures = 0;

    mpy_seq_ctrl #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mpy_a     (mpy_a),
        .mpy_b     (mpy_b),
        .mpy_p     (mpy_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .err       (err),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in multiplier: product ripples through three registers, well inside SETTLE.
    always_ff @(posedge clk) begin
        p1 <= 8'({4'b0000, mpy_a} * {4'b0000, mpy_b});
        p2 <= p1;
        p3 <= p2;
    end
    assign mpy_p = p3 ^ injectMask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for in_ready, then presents one operand pair for exactly one edge.
    task automatic applyStimulus(input int a, input int b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = 4'(a);
        in_b     = 4'(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic runOp(input int a, input int b, input string tag);
        int lat;
        applyStimulus(a, b);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'(SETTLE + 1));
        checkOutput({tag, "_p"}, 32'(out_p), 32'(a * b));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] expP;
        int idx;
        int guard;
        int n;
        int ra;
        int rb;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = 4'd0;
        in_b       = 4'd0;
        out_ready  = 1'b1;
        injectMask = 8'h00;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_p", 32'(out_p), 32'h00);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ops_cnt", 32'(ops_cnt), 32'h00);
        checkOutput("rst_mpy_a", 32'(mpy_a), 32'd0);
        tick();
        rst_n = 1'b1;
        checkOutput("rel_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] basic product 15x15");
        applyStimulus(15, 15);
        checkOutput("basic_busy_E", 32'(in_ready), 32'd0);
        checkOutput("basic_mpy_a", 32'(mpy_a), 32'd15);
        for (int k = 1; k <= SETTLE; k++) begin
            tick();
            checkOutput("basic_busy", 32'(in_ready), 32'd0);
            checkOutput("basic_early_valid", 32'(out_valid), 32'd0);
        end
        tick();
        checkOutput("basic_valid", 32'(out_valid), 32'd1);
        checkOutput("basic_p", 32'(out_p), 32'hE1);
        checkOutput("basic_ops", 32'(ops_cnt), 32'd1);
        checkOutput("basic_err", 32'(err), 32'd0);
        checkOutput("basic_ready_back", 32'(in_ready), 32'd1);

        $display("[TB] backpressure");
        doReset();
        out_ready = 1'b0;
        applyStimulus(3, 5);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        checkOutput("bp_first_p", 32'(out_p), 32'h0F);
        applyStimulus(7, 9);
        for (int k = 0; k < SETTLE + 4; k++) begin
            tick();
            checkOutput("bp_hold_p", 32'(out_p), 32'h0F);
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        checkOutput("bp_stalled", 32'(in_ready), 32'd0);
        checkOutput("bp_ops_stall", 32'(ops_cnt), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_second_p", 32'(out_p), 32'h3F);
        checkOutput("bp_no_gap", 32'(out_valid), 32'd1);
        checkOutput("bp_ops", 32'(ops_cnt), 32'd2);
        checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        checkOutput("bp_keep_p", 32'(out_p), 32'h3F);
        checkOutput("bp_keep_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_drained", 32'(out_valid), 32'd0);

        $display("[TB] corner operands");
        runOp(0, 9, "c0x9");
        runOp(1, 1, "c1x1");
        runOp(15, 1, "c15x1");
        runOp(8, 8, "c8x8");

        $display("[TB] random operands");
        for (int k = 0; k < 6; k++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            runOp(ra, rb, "rand");
        end

        $display("[TB] reset mid-operation");
        applyStimulus(12, 13);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_out_p", 32'(out_p), 32'h00);
        checkOutput("mid_ops", 32'(ops_cnt), 32'h00);
        checkOutput("mid_mpy_b", 32'(mpy_b), 32'd0);
        tick();
        rst_n = 1'b1;
        checkOutput("mid_rel_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < SETTLE + 4; k++) begin
            tick();
            checkOutput("mid_no_product", 32'(out_valid), 32'd0);
        end
        runOp(2, 3, "mid_2x3");

        $display("[TB] exhaustive sweep");
        doReset();
        idx   = 0;
        guard = 0;
        while ((idx < 256 || q.size() != 0) && guard < 8000) begin
            in_valid  = (idx < 256);
            in_a      = 4'(idx / 16);
            in_b      = 4'(idx % 16);
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (q.size() != 0) begin
                    expP = q.pop_front();
                    checkOutput("sweep_p", 32'(out_p), 32'(expP));
                end else begin
                    checkOutput("sweep_unexpected", 32'(out_p), 32'hFFFF);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(8'((idx / 16) * (idx % 16)));
                idx++;
            end
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("sweep_all_accepted", 32'(idx), 32'd256);
        checkOutput("sweep_drained", 32'(q.size()), 32'd0);
        checkOutput("sweep_err", 32'(err), 32'd0);
        checkOutput("sweep_ops_wrap", 32'(ops_cnt), 32'h00);

        $display("[TB] checker injection");
        applyStimulus(5, 6);
        injectMask = 8'h10;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        injectMask = 8'h00;
        checkOutput("inj_p", 32'(out_p), 32'h0E);
        checkOutput("inj_err", 32'(err), 32'd1);
        runOp(2, 2, "post_inj");
        checkOutput("inj_sticky1", 32'(err), 32'd1);
        runOp(15, 15, "post_inj2");
        checkOutput("inj_sticky2", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("inj_err_cleared", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
